// File: rtl/banked_memory_port_if.sv
`default_nettype none
// ============================================================================
// Module      : banked_memory_port_if
// Description : Core request/response, local RAM and bank bus signals of the
//               banked memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface banked_memory_port_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_address;
    logic        req_banked;
    logic        req_write;
    logic [15:0] req_data;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_error;
    logic [15:0] local_address;
    logic        local_write_enable;
    logic [15:0] local_data_out;
    logic [15:0] local_data_in;
    logic        bank_valid;
    logic        bank_ready;
    logic [15:0] bank_address;
    logic        bank_write;
    logic [15:0] bank_data_out;
    logic        bank_resp_valid;
    logic [15:0] bank_data_in;

    modport slave (
        input  req_valid, req_address, req_banked, req_write, req_data,
        output req_ready, resp_valid, resp_data, resp_error,
        output local_address, local_write_enable, local_data_out,
        input  local_data_in,
        output bank_valid, bank_address, bank_write, bank_data_out,
        input  bank_ready, bank_resp_valid, bank_data_in
    );

    modport master (
        output req_valid, req_address, req_banked, req_write, req_data,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  local_address, local_write_enable, local_data_out,
        output local_data_in,
        input  bank_valid, bank_address, bank_write, bank_data_out,
        output bank_ready, bank_resp_valid, bank_data_in
    );
endinterface
`default_nettype wire

// File: rtl/banked_memory_port.sv
`default_nettype none
// ============================================================================
// Module      : banked_memory_port
// Description : Routes one core request at a time to local synchronous RAM or
//               to the bank bus (valid/ready with timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module banked_memory_port #(
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    banked_memory_port_if.slave  bus
);

    localparam logic [2:0] c_st_idle          = 3'd0;
    localparam logic [2:0] c_st_local         = 3'd1;
    localparam logic [2:0] c_st_local_capture = 3'd2;
    localparam logic [2:0] c_st_bank_req      = 3'd3;
    localparam logic [2:0] c_st_bank_resp     = 3'd4;
    localparam logic [2:0] c_st_respond       = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        write_q, write_d;
    logic        banked_q, banked_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic w_idle_ready;
    logic w_timeout;

    assign w_idle_ready = (state_q == c_st_idle) & reset;
    // Fires on the cycle whose closing edge brings the wait count up to TIMEOUT.
    assign w_timeout    = ((17'(wait_cnt_q) + 17'd1) == 17'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= c_st_idle;
            addr_q       <= '0;
            data_q       <= '0;
            write_q      <= 1'b0;
            banked_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            write_q      <= write_d;
            banked_q     <= banked_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        write_d      = write_q;
        banked_d     = banked_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            c_st_idle: begin
                if (bus.req_valid && w_idle_ready) begin
                    addr_d   = bus.req_address;
                    data_d   = bus.req_data;
                    write_d  = bus.req_write;
                    banked_d = bus.req_banked;
                    if (bus.req_banked) begin
                        wait_cnt_d = '0;
                        state_d    = c_st_bank_req;
                    end else begin
                        state_d    = c_st_local;
                    end
                end
            end
            c_st_local: state_d = c_st_local_capture;
            c_st_local_capture: begin
                resp_data_d  = write_q ? 16'h0000 : bus.local_data_in;
                resp_error_d = 1'b0;
                state_d      = c_st_respond;
            end
            c_st_bank_req: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                // A handshake landing on the timeout edge still loses.
                if (w_timeout) begin
                    resp_data_d  = 16'hFFFF;
                    resp_error_d = 1'b1;
                    state_d      = c_st_respond;
                end else if (bus.bank_ready) begin
                    state_d = c_st_bank_resp;
                end
            end
            c_st_bank_resp: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                // A reply landing on the timeout edge wins over the error.
                if (bus.bank_resp_valid) begin
                    resp_data_d  = write_q ? 16'h0000 : bus.bank_data_in;
                    resp_error_d = 1'b0;
                    state_d      = c_st_respond;
                end else if (w_timeout) begin
                    resp_data_d  = 16'hFFFF;
                    resp_error_d = 1'b1;
                    state_d      = c_st_respond;
                end
            end
            c_st_respond: state_d = c_st_idle;
            default:      state_d = c_st_idle;
        endcase
    end

    always_comb begin
        bus.req_ready          = w_idle_ready;
        bus.resp_valid         = (state_q == c_st_respond) & reset;
        bus.resp_data          = resp_data_q;
        bus.resp_error         = resp_error_q;
        bus.local_address      = '0;
        bus.local_write_enable = 1'b0;
        bus.local_data_out     = '0;
        bus.bank_valid         = 1'b0;
        bus.bank_address       = '0;
        bus.bank_write         = 1'b0;
        bus.bank_data_out      = '0;
        if ((state_q == c_st_local) && reset) begin
            bus.local_address      = addr_q;
            bus.local_write_enable = write_q;
            bus.local_data_out     = data_q;
        end
        if ((state_q == c_st_bank_req) && banked_q && reset) begin
            bus.bank_valid    = 1'b1;
            bus.bank_address  = addr_q;
            bus.bank_write    = write_q;
            bus.bank_data_out = data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_memory_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_memory_port
// Description : Self-checking bench for banked_memory_port with a RAM model,
//               a scripted bank responder and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_banked_memory_port;

    localparam int T = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    banked_memory_port_if bus();

    banked_memory_port #(.TIMEOUT(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] ram [0:255];
    logic [15:0] ram_rd;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.local_write_enable) ram[bus.local_address[7:0]] <= bus.local_data_out;
        ram_rd <= ram[bus.local_address[7:0]];
    end
    assign bus.local_data_in = ram_rd;

    logic [15:0] model_mem [0:255];
    int total = 0;
    int bad   = 0;

    // Drives one request and the bank responder; reports what was observed.
    task automatic do_req(input bit banked, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int a_dly, input int b_dly,
                          input logic [15:0] bdata,
                          output int lat, output logic [15:0] rdata, output logic rerr,
                          output int bv_cyc, output int we_cyc, output logic [15:0] we_addr,
                          output logic [15:0] we_data, output int bad_bus, output int extra,
                          output int rdy_k);
        int guard;
        lat = -1; rdata = '0; rerr = 1'b0; bv_cyc = 0; we_cyc = 0; we_addr = '0;
        we_data = '0; bad_bus = 0; extra = 0; rdy_k = -1;
        @(negedge clock);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        bus.req_valid   = 1'b1;
        bus.req_banked  = banked;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_data    = wdata;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.bank_valid) begin
                bv_cyc++;
                if (bus.bank_address !== addr || bus.bank_write !== wr || bus.bank_data_out !== wdata)
                    bad_bus++;
            end else if (bus.bank_address !== 16'h0 || bus.bank_write !== 1'b0 || bus.bank_data_out !== 16'h0) begin
                bad_bus++;
            end
            if (bus.local_write_enable) begin
                we_cyc++;
                we_addr = bus.local_address;
                we_data = bus.local_data_out;
            end
            if (banked && (bus.local_address !== 16'h0 || bus.local_data_out !== 16'h0 || bus.local_write_enable !== 1'b0))
                bad_bus++;
            if (bus.resp_valid) begin
                if (lat < 0) begin
                    lat   = k;
                    rdata = bus.resp_data;
                    rerr  = bus.resp_error;
                end else begin
                    extra++;
                end
            end
            if (bus.req_ready && rdy_k < 0) rdy_k = k;
            bus.bank_ready      = (k == 1 + a_dly);
            bus.bank_resp_valid = (k == 1 + a_dly + b_dly);
            bus.bank_data_in    = bus.bank_resp_valid ? bdata : 16'($urandom);
            if (lat >= 0 && k >= lat + 3) break;
        end
        bus.bank_ready      = 1'b0;
        bus.bank_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            pre_we   = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i == 16'h10) ? 16'hBEEF : 16'($urandom);
            model_mem[i] = pre_data;
        end
        @(negedge clock);
        pre_we = 1'b0;
        total++;
        if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0 || bus.resp_data !== 16'h0) begin
            bad++; $display("FAIL reset_resp got=%b/%b/%h exp=0/0/0000", bus.resp_valid, bus.resp_error, bus.resp_data);
        end
        total++;
        if (bus.bank_valid !== 1'b0 || bus.local_write_enable !== 1'b0 || bus.local_address !== 16'h0) begin
            bad++; $display("FAIL reset_bus got bv=%b we=%b la=%h exp=0", bus.bank_valid, bus.local_write_enable, bus.local_address);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_local_read();
        int lat, bv, we, bb, ex, rk; logic [15:0] rd, wa, wd; logic re;
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, 0, 1, 16'h0, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL local_rd_lat got=%0d exp=3", lat); end
        total++;
        if (rd !== 16'hBEEF || re !== 1'b0) begin bad++; $display("FAIL local_rd_data got=%h/%b exp=beef/0", rd, re); end
        total++;
        if (bv !== 0 || ex !== 0 || we !== 0) begin bad++; $display("FAIL local_rd_side got bv=%0d extra=%0d we=%0d exp=0", bv, ex, we); end
        total++;
        if (rk !== 4) begin bad++; $display("FAIL local_rd_ready got=%0d exp=4", rk); end
    endtask

    task automatic test_local_write();
        int lat, bv, we, bb, ex, rk; logic [15:0] rd, wa, wd; logic re;
        do_req(1'b0, 1'b1, 16'h0020, 16'h1234, 2, 1, 16'h0, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        model_mem[8'h20] = 16'h1234;
        total++;
        if (we !== 1 || wa !== 16'h0020 || wd !== 16'h1234) begin
            bad++; $display("FAIL local_wr_strobe got cyc=%0d a=%h d=%h exp=1/0020/1234", we, wa, wd);
        end
        total++;
        if (lat !== 3 || rd !== 16'h0 || re !== 1'b0) begin bad++; $display("FAIL local_wr_resp got=%0d/%h/%b exp=3/0000/0", lat, rd, re); end
        do_req(1'b0, 1'b0, 16'h0020, 16'h0, 0, 1, 16'h0, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== 3 || rd !== 16'h1234) begin bad++; $display("FAIL local_wr_readback got=%0d/%h exp=3/1234", lat, rd); end
    endtask

    task automatic test_bank_stall();
        int lat, bv, we, bb, ex, rk; logic [15:0] rd, wa, wd; logic re;
        do_req(1'b1, 1'b0, 16'h8000, 16'h0, 3, 2, 16'hCAFE, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (bv !== 4 || bb !== 0) begin bad++; $display("FAIL bank_stall_valid got cyc=%0d badbus=%0d exp=4/0", bv, bb); end
        total++;
        if (lat !== 7 || rd !== 16'hCAFE || re !== 1'b0) begin
            bad++; $display("FAIL bank_stall_resp got=%0d/%h/%b exp=7/cafe/0", lat, rd, re);
        end
    endtask

    task automatic test_timeout();
        int lat, bv, we, bb, ex, rk, late; logic [15:0] rd, wa, wd; logic re;
        do_req(1'b1, 1'b0, 16'h8100, 16'h0, 1000, 1, 16'h0, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== T + 1 || rd !== 16'hFFFF || re !== 1'b1) begin
            bad++; $display("FAIL timeout_resp got=%0d/%h/%b exp=%0d/ffff/1", lat, rd, re, T + 1);
        end
        total++;
        if (bv !== T || ex !== 0) begin bad++; $display("FAIL timeout_valid got cyc=%0d extra=%0d exp=%0d/0", bv, ex, T); end
        late = 0;
        @(negedge clock);
        bus.bank_resp_valid = 1'b1;
        bus.bank_data_in    = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.bank_resp_valid = 1'b0;
            if (bus.resp_valid) late++;
        end
        total++;
        if (late !== 0) begin bad++; $display("FAIL timeout_late_resp got=%0d exp=0", late); end
        // Handshake on the timeout edge: the timeout must win.
        do_req(1'b1, 1'b0, 16'h8200, 16'h0, T - 1, 1, 16'h1111, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== T + 1 || rd !== 16'hFFFF || re !== 1'b1 || bv !== T) begin
            bad++; $display("FAIL timeout_ready_tie got=%0d/%h/%b/%0d exp=%0d/ffff/1/%0d", lat, rd, re, bv, T + 1, T);
        end
    endtask

    task automatic test_timeout_tie();
        int lat, bv, we, bb, ex, rk; logic [15:0] rd, wa, wd; logic re;
        do_req(1'b1, 1'b0, 16'h8300, 16'h0, 0, T - 1, 16'h5555, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== T + 1 || rd !== 16'h5555 || re !== 1'b0) begin
            bad++; $display("FAIL timeout_resp_tie got=%0d/%h/%b exp=%0d/5555/0", lat, rd, re, T + 1);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bv, we, bb, ex, rk, hits; logic [15:0] rd, wa, wd; logic re;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_banked = 1'b1; bus.req_write = 1'b0;
        bus.req_address = 16'h8123; bus.req_data = 16'h0;
        @(negedge clock);
        bus.req_valid  = 1'b0;
        bus.bank_ready = 1'b1;
        @(negedge clock);
        bus.bank_ready = 1'b0;
        total++;
        if (bus.bank_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_resp_state got bv=%b exp=0", bus.bank_valid); end
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.bank_resp_valid = (i == 0);
            bus.bank_data_in    = 16'h4242;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) hits++;
        end
        total++;
        if (hits !== 0) begin bad++; $display("FAIL reset_mid_held got=%0d exp=0", hits); end
        reset = 1'b1;
        bus.bank_resp_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.bank_resp_valid = 1'b0;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) hits++;
        end
        total++;
        if (hits !== 0 || bus.resp_data !== 16'h0) begin
            bad++; $display("FAIL reset_mid_abandon got=%0d/%h exp=0/0000", hits, bus.resp_data);
        end
        do_req(1'b0, 1'b0, 16'h0010, 16'h0, 0, 1, 16'h0, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
        total++;
        if (lat !== 3 || rd !== 16'hBEEF || re !== 1'b0) begin
            bad++; $display("FAIL reset_mid_local got=%0d/%h/%b exp=3/beef/0", lat, rd, re);
        end
    endtask

    task automatic test_random();
        int lat, bv, we, bb, ex, rk, a, b, e_lat, e_bv;
        logic [15:0] rd, wa, wd, addr, wdata, bdata, e_data;
        logic re, e_err;
        bit banked, wr;
        for (int n = 0; n < 40; n++) begin
            banked = 1'($urandom_range(0, 1));
            wr     = 1'($urandom_range(0, 1));
            addr   = banked ? 16'($urandom) : 16'($urandom_range(0, 255));
            wdata  = 16'($urandom);
            bdata  = 16'($urandom);
            a      = $urandom_range(0, 8);
            b      = $urandom_range(1, 6);
            // Transaction-level expectation from the access rules.
            if (!banked) begin
                e_lat  = 3;
                e_err  = 1'b0;
                e_data = wr ? 16'h0 : model_mem[addr[7:0]];
                e_bv   = 0;
                if (wr) model_mem[addr[7:0]] = wdata;
            end else if (1 + a + b <= T) begin
                e_lat  = 2 + a + b;
                e_err  = 1'b0;
                e_data = wr ? 16'h0 : bdata;
                e_bv   = a + 1;
            end else begin
                e_lat  = T + 1;
                e_err  = 1'b1;
                e_data = 16'hFFFF;
                e_bv   = (a + 1 < T) ? a + 1 : T;
            end
            do_req(banked, wr, addr, wdata, a, b, bdata, lat, rd, re, bv, we, wa, wd, bb, ex, rk);
            total++;
            if (lat !== e_lat || rd !== e_data || re !== e_err) begin
                bad++; $display("FAIL rand_resp[%0d] got=%0d/%h/%b exp=%0d/%h/%b", n, lat, rd, re, e_lat, e_data, e_err);
            end
            total++;
            if (bv !== e_bv || bb !== 0 || ex !== 0 || rk !== e_lat + 1) begin
                bad++; $display("FAIL rand_bus[%0d] got bv=%0d badbus=%0d extra=%0d rdy=%0d exp=%0d/0/0/%0d", n, bv, bb, ex, rk, e_bv, e_lat + 1);
            end
            total++;
            if ((!banked && wr) ? (we !== 1 || wa !== addr || wd !== wdata) : (we !== 0)) begin
                bad++; $display("FAIL rand_we[%0d] got cyc=%0d a=%h d=%h exp=%0d/%h/%h", n, we, wa, wd, (!banked && wr) ? 1 : 0, addr, wdata);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_banked = 1'b0; bus.req_write = 1'b0;
        bus.req_address = 16'h0; bus.req_data = 16'h0;
        bus.bank_ready = 1'b0; bus.bank_resp_valid = 1'b0; bus.bank_data_in = 16'h0;
        pre_we = 1'b0; pre_addr = 8'h0; pre_data = 16'h0;
        test_reset();
        test_local_read();
        test_local_write();
        test_bank_stall();
        test_timeout();
        test_timeout_tie();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
